// File: rtl/tick_gen_if.sv
// Configuration bus for tick_gen: one divisor/enable write per strobe.
// The master drives the write; tick_gen is the slave.
interface tick_gen_if #(
   parameter int CH_W      = 2,
   parameter int DIV_WIDTH = 16
);
   logic                 cfg_we;
   logic [CH_W-1:0]      cfg_ch;
   logic [DIV_WIDTH-1:0] cfg_div;
   logic                 cfg_en;

   modport master (output cfg_we, output cfg_ch, output cfg_div, output cfg_en);
   modport slave  (input  cfg_we, input  cfg_ch, input  cfg_div, input  cfg_en);
endinterface

// File: rtl/tick_gen.sv
// Multi-channel clock-enable generator: free-running counter bus plus CHANNELS
// programmable dividers, each giving a one-cycle tick and a 50 % square wave.
module tick_gen #(
   parameter int CNT_WIDTH = 32,
   parameter int CHANNELS  = 4,
   parameter int DIV_WIDTH = 16,
   parameter int CH_W      = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   tick_gen_if.slave            cfg,
   output logic [CNT_WIDTH-1:0] freerun,
   output logic [CHANNELS-1:0]  tick,
   output logic [CHANNELS-1:0]  sq,
   output logic [CHANNELS-1:0]  active
);

   logic [CNT_WIDTH-1:0] freerun_q, freerun_d;
   logic [DIV_WIDTH-1:0] div_q [CHANNELS];
   logic [DIV_WIDTH-1:0] div_d [CHANNELS];
   logic [DIV_WIDTH-1:0] cnt_q [CHANNELS];
   logic [DIV_WIDTH-1:0] cnt_d [CHANNELS];
   logic [CHANNELS-1:0]  en_q, en_d;
   logic [CHANNELS-1:0]  tick_q, tick_d;
   logic [CHANNELS-1:0]  sq_q, sq_d;
   logic [CHANNELS-1:0]  wr_sel;

   // Out-of-range channel numbers match no channel, so such writes are dropped.
   always_comb begin
      wr_sel = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         if (cfg.cfg_we && (int'(cfg.cfg_ch) == ch)) wr_sel[ch] = 1'b1;
      end
   end

   always_comb begin
      freerun_d = freerun_q + CNT_WIDTH'(1);
      div_d     = div_q;
      cnt_d     = cnt_q;
      en_d      = en_q;
      tick_d    = '0;
      sq_d      = sq_q;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         if (wr_sel[ch]) begin
            // A write restarts the phase and beats a coincident terminal count.
            div_d[ch] = cfg.cfg_div;
            en_d[ch]  = cfg.cfg_en;
            cnt_d[ch] = '0;
            sq_d[ch]  = 1'b0;
         end else if (!en_q[ch]) begin
            cnt_d[ch] = '0;
            sq_d[ch]  = 1'b0;
         end else if (cnt_q[ch] == div_q[ch]) begin
            cnt_d[ch]  = '0;
            tick_d[ch] = 1'b1;
            sq_d[ch]   = ~sq_q[ch];
         end else begin
            cnt_d[ch] = cnt_q[ch] + DIV_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         freerun_q <= '0;
         en_q      <= '0;
         tick_q    <= '0;
         sq_q      <= '0;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            div_q[ch] <= '0;
            cnt_q[ch] <= '0;
         end
      end else begin
         freerun_q <= freerun_d;
         en_q      <= en_d;
         tick_q    <= tick_d;
         sq_q      <= sq_d;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            div_q[ch] <= div_d[ch];
            cnt_q[ch] <= cnt_d[ch];
         end
      end
   end

   assign freerun = freerun_q;
   assign tick    = tick_q;
   assign sq      = sq_q;
   assign active  = en_q;

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: expected outputs come from per-channel
// arithmetic on the configuration edge number, divisor and enable.
module tb_tick_gen;
   localparam int CNT_W = 8;
   localparam int CH    = 3;
   localparam int DW    = 16;
   localparam int CW    = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [CNT_W-1:0] freerun;
   logic [CH-1:0]    tick, sq, active;

   tick_gen_if #(.CH_W(CW), .DIV_WIDTH(DW)) cfg_if ();

   tick_gen #(.CNT_WIDTH(CNT_W), .CHANNELS(CH), .DIV_WIDTH(DW), .CH_W(CW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cfg     (cfg_if),
      .freerun (freerun),
      .tick    (tick),
      .sq      (sq),
      .active  (active)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   int rst_edge = 0;
   int m_t0 [CH];
   int m_d  [CH];
   bit m_en [CH];
   int n_checks = 0;
   int n_fail = 0;

   // Advance one edge, fold the sampled reset/write into the model, settle.
   task automatic step();
      @(posedge clk);
      edge_n++;
      if (!rst_n) begin
         rst_edge = edge_n;
         for (int c = 0; c < CH; c++) begin
            m_en[c] = 1'b0; m_t0[c] = edge_n; m_d[c] = 0;
         end
      end else if (cfg_if.cfg_we && int'(cfg_if.cfg_ch) < CH) begin
         m_t0[int'(cfg_if.cfg_ch)] = edge_n;
         m_d[int'(cfg_if.cfg_ch)]  = int'(cfg_if.cfg_div);
         m_en[int'(cfg_if.cfg_ch)] = cfg_if.cfg_en;
      end
      #1;
   endtask

   function automatic logic [CNT_W-1:0] exp_fr();
      return CNT_W'(edge_n - rst_edge);
   endfunction

   function automatic logic [CH-1:0] exp_tick();
      logic [CH-1:0] r = '0;
      for (int c = 0; c < CH; c++)
         if (m_en[c] && edge_n > m_t0[c] && ((edge_n - m_t0[c]) % (m_d[c] + 1)) == 0) r[c] = 1'b1;
      return r;
   endfunction

   function automatic logic [CH-1:0] exp_sq();
      logic [CH-1:0] r = '0;
      for (int c = 0; c < CH; c++)
         if (m_en[c] && ((((edge_n - m_t0[c]) / (m_d[c] + 1)) % 2) == 1)) r[c] = 1'b1;
      return r;
   endfunction

   function automatic logic [CH-1:0] exp_act();
      logic [CH-1:0] r = '0;
      for (int c = 0; c < CH; c++) r[c] = m_en[c];
      return r;
   endfunction

   task automatic do_write(int c, int d, bit en);
      cfg_if.cfg_we  = 1'b1;
      cfg_if.cfg_ch  = CW'(c);
      cfg_if.cfg_div = DW'(d);
      cfg_if.cfg_en  = en;
      step();
      cfg_if.cfg_we  = 1'b0;
      cfg_if.cfg_ch  = CW'($urandom_range(0, 3));
      cfg_if.cfg_div = DW'($urandom);
      cfg_if.cfg_en  = 1'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = '0; cfg_if.cfg_div = DW'(2); cfg_if.cfg_en = 1'b1;
      repeat (3) begin
         step();
         n_checks++;
         if (freerun !== '0 || tick !== '0 || sq !== '0 || active !== '0) begin
            n_fail++;
            $display("FAIL reset_state e%0d: fr=%0d tick=%b sq=%b act=%b want all 0", edge_n, freerun, tick, sq, active);
         end
      end
      rst_n = 1'b1;
      cfg_if.cfg_we = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         n_checks++;
         if (freerun !== CNT_W'(i)) begin
            n_fail++; $display("FAIL reset_release_fr: got %0d want %0d", freerun, i);
         end
         n_checks++;
         if (active !== '0) begin
            n_fail++; $display("FAIL reset_idle_active: got %b want 000", active);
         end
      end
   endtask

   task automatic test_basic_divide();
      int t0;
      do_write(0, 3, 1'b1);
      t0 = edge_n;
      for (int k = 0; k <= 13; k++) begin
         if (k > 0) step();
         n_checks++;
         if (tick !== exp_tick()) begin
            n_fail++; $display("FAIL basic_tick E0+%0d: got %b want %b", k, tick, exp_tick());
         end
         n_checks++;
         if (sq !== exp_sq()) begin
            n_fail++; $display("FAIL basic_sq E0+%0d: got %b want %b", k, sq, exp_sq());
         end
         n_checks++;
         if (freerun !== exp_fr() || active !== exp_act()) begin
            n_fail++; $display("FAIL basic_fr_act E0+%0d: got %0d/%b want %0d/%b", k, freerun, active, exp_fr(), exp_act());
         end
      end
      n_checks++;
      if (edge_n - t0 != 13 || sq[0] !== 1'b1) begin
         n_fail++; $display("FAIL basic_sq_e12: got sq0=%b want 1", sq[0]);
      end
   endtask

   task automatic test_write_vs_tc();
      do_write(0, 3, 1'b1);
      repeat (3) step();
      cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = '0; cfg_if.cfg_div = DW'(1); cfg_if.cfg_en = 1'b1;
      step();
      cfg_if.cfg_we = 1'b0;
      n_checks++;
      if (tick[0] !== 1'b0 || sq[0] !== 1'b0) begin
         n_fail++; $display("FAIL write_beats_tc: got tick0=%b sq0=%b want 0/0", tick[0], sq[0]);
      end
      for (int k = 1; k <= 6; k++) begin
         step();
         n_checks++;
         if (tick !== exp_tick() || sq !== exp_sq()) begin
            n_fail++; $display("FAIL rewrite_phase +%0d: got %b/%b want %b/%b", k, tick, sq, exp_tick(), exp_sq());
         end
      end
   endtask

   task automatic test_d0_max();
      do_write(1, 0, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         step();
         n_checks++;
         if (tick[1] !== 1'b1 || sq !== exp_sq() || tick !== exp_tick()) begin
            n_fail++; $display("FAIL d0_ch1 +%0d: got tick=%b sq=%b want %b/%b", k, tick, sq, exp_tick(), exp_sq());
         end
      end
      do_write(2, 16'hFFFF, 1'b1);
      for (int k = 1; k <= 65538; k++) begin
         step();
         n_checks++;
         if (tick !== exp_tick() || sq !== exp_sq() || active !== exp_act() || freerun !== exp_fr()) begin
            n_fail++;
            $display("FAIL dmax +%0d: got t=%b s=%b a=%b f=%0d want %b/%b/%b/%0d",
                     k, tick, sq, active, freerun, exp_tick(), exp_sq(), exp_act(), exp_fr());
         end
         if (k == 65536) begin
            n_checks++;
            if (tick[2] !== 1'b1) begin
               n_fail++; $display("FAIL dmax_first_tick: got %b want 1", tick[2]);
            end
         end
      end
   endtask

   task automatic test_disable_invalid();
      logic [CH-1:0] t_before, s_before;
      do_write(0, 5, 1'b1);
      do_write(1, 2, 1'b1);
      do_write(2, 4, 1'b1);
      repeat (7) step();
      t_before = exp_tick(); s_before = exp_sq();
      do_write(3, 0, 1'b1);
      n_checks++;
      if (active !== 3'b111 || tick !== exp_tick() || sq !== exp_sq()) begin
         n_fail++; $display("FAIL invalid_ch: got a=%b t=%b s=%b want 111/%b/%b", active, tick, sq, exp_tick(), exp_sq());
      end
      step(); step();
      do_write(0, 7, 1'b0);
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) step();
         n_checks++;
         if (tick[0] !== 1'b0 || sq[0] !== 1'b0 || active[0] !== 1'b0) begin
            n_fail++; $display("FAIL disable_ch0 +%0d: got t=%b s=%b a=%b want 0", k, tick[0], sq[0], active[0]);
         end
         n_checks++;
         if (tick !== exp_tick() || sq !== exp_sq() || active !== exp_act()) begin
            n_fail++; $display("FAIL indep +%0d: got %b/%b/%b want %b/%b/%b", k, tick, sq, active, exp_tick(), exp_sq(), exp_act());
         end
      end
   endtask

   task automatic test_random_wrap();
      rst_n = 1'b0; step(); rst_n = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         cfg_if.cfg_we  = ($urandom_range(0, 7) == 0);
         cfg_if.cfg_ch  = CW'($urandom_range(0, 3));
         cfg_if.cfg_div = DW'($urandom_range(0, 9));
         cfg_if.cfg_en  = ($urandom_range(0, 3) != 0);
         step();
         n_checks++;
         if (tick !== exp_tick() || sq !== exp_sq() || active !== exp_act() || freerun !== exp_fr()) begin
            n_fail++;
            $display("FAIL random +%0d: got t=%b s=%b a=%b f=%0d want %b/%b/%b/%0d",
                     k, tick, sq, active, freerun, exp_tick(), exp_sq(), exp_act(), exp_fr());
         end
      end
      cfg_if.cfg_we = 1'b0;
      n_checks++;
      if (freerun !== 8'd44) begin
         n_fail++; $display("FAIL wrap_final: got %0d want 44", freerun);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0; cfg_if.cfg_en = 1'b0;
      for (int c = 0; c < CH; c++) begin m_t0[c] = 0; m_d[c] = 0; m_en[c] = 1'b0; end
      test_reset();
      test_basic_divide();
      test_write_vs_tc();
      test_d0_max();
      test_disable_invalid();
      test_random_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised multi-channel clock-enable generator replacing the single free-running divider counter. It keeps a free-running counter bus for legacy taps. It adds CHANNELS independently programmable dividers. Each divider produces a one-cycle tick (clock enable) and a 50 % square wave. It sits at the top of the clock domain and feeds enables to display scanning, debouncers, UART baud logic and single-step control without creating derived clocks.

## Interface
- CNT_WIDTH, 32: width of the free-running counter bus.
- CHANNELS, 4: number of programmable divider channels (1..16).
- DIV_WIDTH, 16: width of each channel's divisor register.
- CH_W, 2: width of the channel select; must be ≥ max(1, ceil(log2(CHANNELS))).
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- cfg_we  in  1  configuration write strobe, one cycle per write.
- cfg_ch  in  CH_W  channel addressed by the write.
- cfg_div  in  DIV_WIDTH  divisor value D; tick period is D+1 cycles.
- cfg_en  in  1  channel enable written together with cfg_div.
- freerun  out  CNT_WIDTH  free-running cycle counter; bit k toggles at clk/2^(k+1).
- tick  out  CHANNELS  per-channel one-cycle enable pulse, registered.
- sq  out  CHANNELS  per-channel square wave, registered.
- active  out  CHANNELS  per-channel enable state (en_q).

## Operation
- Reset (rst_n=0 at an edge) sets:
  - freerun=0;
  - for every channel: div_q=0, en_q=0, cnt=0, tick=0, sq=0;
  - active=0.
- Reset overrides cfg_we in the same cycle.
- freerun increments by 1 every non-reset cycle. It wraps from 2^CNT_WIDTH−1 to 0 with no flag.
- Per channel, each cycle, in priority order:
  1. Config write: cfg_we=1 and cfg_ch selects this channel. Then div_q←cfg_div, en_q←cfg_en, cnt←0, tick←0, sq←0. This restarts the phase even if the values are unchanged. A write always wins over a coincident terminal count, and no tick is emitted.
  2. Disabled (en_q=0): cnt←0, tick←0, sq←0.
  3. Terminal count (en_q=1, cnt==div_q): cnt←0, tick←1, sq←~sq.
  4. Otherwise (en_q=1, cnt<div_q): cnt←cnt+1, tick←0.
- cnt is DIV_WIDTH wide and never exceeds div_q.
- D=0: tick stays high continuously and sq toggles every cycle (clk/2).
- D=2^DIV_WIDTH−1: the period is 2^DIV_WIDTH cycles. No overflow is possible.
- Writes with cfg_ch ≥ CHANNELS are ignored entirely. No channel changes.
- Only one channel can be written per cycle. All other channels continue undisturbed.
- Channels are fully independent. They share no counters with each other or with freerun.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reference edge: let E0 be the edge that samples cfg_we=1 with cfg_en=1 and divisor D.
- First tick: tick is first high in the cycle after edge E(D+1), i.e. tick is registered at edge E0+D+1. It is then high after every edge E0+k(D+1), k≥1, for exactly one cycle, except when D=0.
- sq rises at edge E0+(D+1) and falls at E0+2(D+1). Its period is 2(D+1) cycles with a 50 % duty cycle.
- active follows en_q, updated at E0.
- Disabling write at edge Ew: tick, sq and active are 0 from Ew onward. A tick that would have been registered at Ew is suppressed.
- Reset mid-count: at the reset edge all channel state clears. After reset the channels stay idle until they are reconfigured.
- freerun equals the number of non-reset edges since the last reset edge, mod 2^CNT_WIDTH.

## Test plan
- Reset check: hold rst_n=0 for 3 cycles with cfg_we=1 and cfg_ch=0 → freerun=0, tick=0, sq=0 and active=0 throughout. After release, freerun reads 1, 2, 3… on successive edges.
- Basic divide: write ch0 with D=3, en=1 at E0 → tick[0] registered at E4, E8, E12 and never otherwise. sq[0] rises at E4, falls at E8, rises at E12.
- D=0 and max: for ch1 with D=0 → tick[1] is constantly 1 and sq[1] toggles every cycle. For ch2 with D=0xFFFF → first tick at E0+65536.
- Write vs terminal count: ch0 has D=3. Rewrite ch0 with D=1 exactly at the edge where cnt==3 → no tick at that edge. The next ticks are at +2 and +4. sq restarts from 0.
- Disable, invalid address, independence: with CHANNELS=3, write cfg_ch=3 → no change in any channel. Then disable ch0 mid-count → tick[0]=sq[0]=active[0]=0 from that edge. ch1 keeps its phase unchanged.
- Wrap: with CNT_WIDTH=8, run 300 cycles → freerun goes 255→0 and then continues to 44.
